// File: rtl/time_seek_addr.sv
// BCD mm:ss seek time to RAM playback address converter.
// Iterative: one BCD second down per clock, binary seconds up, saturating.
//
// Ports:
//   sys_clk, sys_rst_n      : clock, async active-low reset
//   seek_req, seek_time     : one-cycle request with BCD {mt,mo,st,so}
//   seek_busy               : conversion in progress
//   seek_done, seek_err     : one-cycle completion / invalid-input pulses
//   seek_clamped            : result saturated at SEC_MAX (valid with done)
//   seek_addr               : seconds << SEC_SHIFT, held between seeks
module time_seek_addr #(
  parameter int ADDR_W    = 12,
  parameter int SEC_SHIFT = 2,
  parameter int SEC_MAX   = 1023
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              seek_req,
  input  logic [15:0]       seek_time,
  output logic              seek_busy,
  output logic              seek_done,
  output logic              seek_err,
  output logic              seek_clamped,
  output logic [ADDR_W-1:0] seek_addr
);

  localparam int CNT_W = ADDR_W - SEC_SHIFT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_COUNT,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]       r_bcd;
  logic [15:0]       w_dec;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_new;
  logic              r_clamped;
  logic              w_b0;
  logic              w_b1;
  logic              w_b2;
  logic              w_zero;
  logic              w_sat;
  logic              w_last;
  logic              w_invalid;

  // Borrow chain: each digit borrows only when all lower digits are 0.
  assign w_b0 = (r_bcd[3:0] == 4'd0);
  assign w_b1 = w_b0 && (r_bcd[7:4] == 4'd0);
  assign w_b2 = w_b1 && (r_bcd[11:8] == 4'd0);

  always_comb begin
    w_dec = r_bcd;
    w_dec[3:0] = w_b0 ? 4'd9 : r_bcd[3:0] - 4'd1;
    if (w_b0)
      w_dec[7:4] = (r_bcd[7:4] == 4'd0) ? 4'd5 : r_bcd[7:4] - 4'd1;
    if (w_b1)
      w_dec[11:8] = (r_bcd[11:8] == 4'd0) ? 4'd9 : r_bcd[11:8] - 4'd1;
    if (w_b2)
      w_dec[15:12] = r_bcd[15:12] - 4'd1;
  end

  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_zero     = (w_dec == 16'h0000);
  assign w_sat      = (w_cnt_inc == CNT_W'(SEC_MAX));
  assign w_last     = w_zero || w_sat;
  assign w_addr_new = {w_cnt_inc, {SEC_SHIFT{1'b0}}};

  assign w_invalid = (r_bcd[15:12] > 4'd9) || (r_bcd[11:8] > 4'd9) ||
                     (r_bcd[7:4] > 4'd5)   || (r_bcd[3:0] > 4'd9);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (seek_req) w_next = S_CHECK;
      S_CHECK: begin
        if (w_invalid)             w_next = S_ERR;
        else if (r_bcd == 16'h0)   w_next = S_DONE;
        else                       w_next = S_COUNT;
      end
      S_COUNT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_clamped <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (seek_req) begin
            r_bcd     <= seek_time;
            r_cnt     <= '0;
            r_clamped <= 1'b0;
          end
        end
        S_CHECK: begin
          if (!w_invalid && r_bcd == 16'h0)
            r_addr <= '0;
        end
        S_COUNT: begin
          r_bcd <= w_dec;
          r_cnt <= w_cnt_inc;
          if (w_last) begin
            r_addr    <= w_addr_new;
            // An exact SEC_MAX seconds entry is not a saturation.
            r_clamped <= w_sat && !w_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign seek_busy    = (r_state != S_IDLE);
  assign seek_done    = (r_state == S_DONE);
  assign seek_err     = (r_state == S_ERR);
  assign seek_clamped = r_clamped;
  assign seek_addr    = r_addr;

endmodule

// File: tb/tb_time_seek_addr.sv
// Self-checking bench for time_seek_addr.
// Scoreboard of expected done/err events with latency, popped on output.
module tb_time_seek_addr;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        seek_req = 1'b0;
  logic [15:0] seek_time = 16'h0;
  logic        seek_busy;
  logic        seek_done;
  logic        seek_err;
  logic        seek_clamped;
  logic [11:0] seek_addr;

  time_seek_addr #(
    .ADDR_W(12),
    .SEC_SHIFT(2),
    .SEC_MAX(1023)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .seek_req(seek_req),
    .seek_time(seek_time),
    .seek_busy(seek_busy),
    .seek_done(seek_done),
    .seek_err(seek_err),
    .seek_clamped(seek_clamped),
    .seek_addr(seek_addr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          err;
    bit          clamp;
    logic [11:0] addr;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [11:0] exp_addr = 12'd0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      cyc++;
      if (seek_done && seek_err) chk("excl", 1, 0);
      if (seek_done || seek_err) begin
        if (q.size() == 0) begin
          chk("spurious", 1, 0);
        end else begin
          e = q.pop_front();
          chk("kind", {31'd0, seek_err}, {31'd0, e.err});
          chk("addr", {20'd0, seek_addr}, {20'd0, e.addr});
          if (!e.err) chk("clamp", {31'd0, seek_clamped}, {31'd0, e.clamp});
          chk("lat", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic seek(input logic [15:0] t, input bit wait_done);
    exp_t e;
    int   secs;
    int   n;
    bit   ok;
    ok = (t[15:12] <= 9) && (t[11:8] <= 9) && (t[7:4] <= 5) && (t[3:0] <= 9);
    secs = t[15:12] * 600 + t[11:8] * 60 + t[7:4] * 10 + t[3:0];
    @(negedge sys_clk);
    e.err = !ok;
    if (ok) begin
      n = (secs > 1023) ? 1023 : secs;
      exp_addr = 12'(n << 2);
      e.clamp = (secs > 1023);
      e.lat = n + 1;
    end else begin
      e.clamp = 1'b0;
      e.lat = 1;
    end
    e.addr = exp_addr;
    e.acc = cyc + 1;
    q.push_back(e);
    seek_time = t;
    seek_req = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("busy", {31'd0, seek_busy}, 1);
    @(negedge sys_clk);
    seek_req = 1'b0;
    seek_time = 16'hFFFF;
    if (wait_done) begin
      n = 0;
      while (q.size() != 0 && n < 1200) begin
        @(posedge sys_clk);
        n++;
      end
      if (q.size() != 0) begin
        chk("timeout", 1, 0);
        q.delete();
      end
      repeat (2) @(negedge sys_clk);
      chk("idle", {31'd0, seek_busy}, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", {31'd0, seek_busy}, 0);
    chk("rst_done", {31'd0, seek_done}, 0);
    chk("rst_err", {31'd0, seek_err}, 0);
    chk("rst_clamp", {31'd0, seek_clamped}, 0);
    chk("rst_addr", {20'd0, seek_addr}, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    seek(16'h0000, 1);
    seek(16'h0105, 1);
    seek(16'h0059, 1);
    seek(16'h0100, 1);
    seek(16'h0060, 1);
    seek(16'h00A0, 1);
    seek(16'h9959, 1);
    seek(16'h0001, 1);
    seek(16'h1A00, 1);
    seek(16'h0010, 1);

    // Request while counting must be ignored.
    seek(16'h0200, 0);
    repeat (20) @(negedge sys_clk);
    seek_time = 16'h0001;
    seek_req = 1'b1;
    @(negedge sys_clk);
    seek_req = 1'b0;
    repeat (150) @(negedge sys_clk);
    chk("ign_q", q.size(), 0);
    q.delete();
    chk("ign_addr", {20'd0, seek_addr}, 480);

    // Reset mid-count: outputs drop at once, no pulse afterwards.
    seek(16'h0200, 0);
    repeat (30) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, seek_busy}, 0);
    chk("mid_done", {31'd0, seek_done}, 0);
    chk("mid_err", {31'd0, seek_err}, 0);
    chk("mid_clamp", {31'd0, seek_clamped}, 0);
    chk("mid_addr", {20'd0, seek_addr}, 0);
    q.delete();
    exp_addr = 12'd0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (150) @(negedge sys_clk);
    chk("post_busy", {31'd0, seek_busy}, 0);
    chk("post_addr", {20'd0, seek_addr}, 0);

    seek(16'h0002, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
